// File: rtl/rr_decoder_sched.sv
// rtl/rr_decoder_sched.sv - round-robin scheduler driving decoder4X16 selects/enable
module rr_decoder_sched #(
  parameter int N        = 16,
  parameter int IDXW     = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [IDXW-1:0] grant_idx,
  output logic            grant_en,
  output logic            timeout,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t          state, state_nx;
  logic [IDXW-1:0] ptr, ptr_nx, idx_nx, winner, cand;
  logic            found;
  logic [7:0]      hold_cnt, hold_nx;
  logic            en_nx, to_nx, busy_nx;
  logic            release_c, limit_c;

  // first requester at or after ptr, wrapping around the 16 slots
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < N; i++) begin
      cand = ptr + IDXW'(i);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // next-state and next registered outputs; grant_en only rises alongside GRANT
  always_comb begin
    state_nx  = state;
    idx_nx    = grant_idx;
    ptr_nx    = ptr;
    hold_nx   = hold_cnt;
    en_nx     = 1'b0;
    to_nx     = 1'b0;
    busy_nx   = 1'b0;
    release_c = done || !req[grant_idx];
    limit_c   = (hold_cnt == HOLD_LAST);
    case (state)
      IDLE: begin
        if (found) begin
          state_nx = GRANT;
          idx_nx   = winner;
          hold_nx  = '0;
          en_nx    = 1'b1;
          busy_nx  = 1'b1;
        end
      end
      GRANT: begin
        busy_nx = 1'b1;
        if (hold_cnt != 8'hFF) hold_nx = hold_cnt + 8'd1;
        if (release_c || limit_c) begin
          state_nx = RELEASE;
          // a voluntary release on the last allowed cycle is not a timeout
          to_nx    = !release_c;
        end else begin
          en_nx = 1'b1;
        end
      end
      RELEASE: begin
        state_nx = IDLE;
        ptr_nx   = grant_idx + 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // state and output registers; reset wins over any grant in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant_idx <= '0;
      grant_en  <= 1'b0;
      timeout   <= 1'b0;
      busy      <= 1'b0;
      ptr       <= '0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_nx;
      grant_idx <= idx_nx;
      grant_en  <= en_nx;
      timeout   <= to_nx;
      busy      <= busy_nx;
      ptr       <= ptr_nx;
      hold_cnt  <= hold_nx;
    end
  end

endmodule

// File: tb/tb_rr_decoder_sched.sv
// tb/tb_rr_decoder_sched.sv - self-checking bench for rr_decoder_sched
module tb_rr_decoder_sched;

  localparam int MAX_HOLD = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] req = '0;
  logic        done = 1'b0;
  logic [3:0]  grant_idx;
  logic        grant_en;
  logic        timeout;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  rr_decoder_sched #(.N(16), .IDXW(4), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .grant_idx (grant_idx),
    .grant_en  (grant_en),
    .timeout   (timeout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // reference model: who owns the resource, for how many cycles, and the rotation pointer
  int m_owner = -1;
  int m_held  = 0;
  int m_gap   = 0;
  int m_ptr   = 0;
  int m_last  = 0;
  bit m_to    = 0;
  bit m_valid = 0;
  bit m_rel;

  // model advances on each edge from the inputs sampled there
  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1; m_held = 0; m_gap = 0; m_ptr = 0; m_last = 0; m_to = 0; m_valid = 1;
    end else if (m_owner >= 0) begin
      m_rel = done || !req[m_owner];
      if (m_rel || m_held == MAX_HOLD) begin
        m_to = !m_rel;
        m_owner = -1;
        m_gap = 1;
      end else begin
        m_held++;
        m_to = 0;
      end
    end else if (m_gap != 0) begin
      m_gap = 0;
      m_ptr = (m_last + 1) % 16;
      m_to = 0;
    end else begin
      m_to = 0;
      for (int k = 0; k < 16; k++) begin
        if (req[(m_ptr + k) % 16]) begin
          m_owner = (m_ptr + k) % 16;
          m_last = m_owner;
          m_held = 1;
          break;
        end
      end
    end
  end

  // compare DUT against the model mid-cycle
  always @(negedge clk) begin
    if (m_valid) begin
      chk("mdl_en",   grant_en,  (m_owner >= 0) ? 1 : 0);
      chk("mdl_idx",  grant_idx, m_last);
      chk("mdl_to",   timeout,   m_to);
      chk("mdl_busy", busy,      (m_owner >= 0 || m_gap != 0) ? 1 : 0);
    end
  end

  typedef struct {
    logic [15:0] req;
    logic        done;
    logic        rst;
    logic        en;
    logic [3:0]  idx;
    logic        to;
    logic        busy;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [15:0] r, input logic d, input logic rs,
                              input logic en, input logic [3:0] idx, input logic to,
                              input logic bz);
    vec_t v;
    v.req = r; v.done = d; v.rst = rs; v.en = en; v.idx = idx; v.to = to; v.busy = bz;
    tbl.push_back(v);
  endfunction

  task automatic cyc(input logic [15:0] r, input logic d, input logic rs);
    req = r; done = d; rst = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [15:0] rr;
  int cnt;

  initial begin
    // reset held with everyone requesting, then first grant
    add(16'hFFFF, 0, 1, 0, 0, 0, 0);
    add(16'hFFFF, 0, 1, 0, 0, 0, 0);
    add(16'hFFFF, 0, 0, 1, 0, 0, 1);
    add(16'h0000, 0, 0, 0, 0, 0, 1);
    add(16'h0020, 0, 0, 0, 0, 0, 0);
    // single requester 5, three grant cycles, then ptr must be 6
    add(16'h0020, 0, 0, 1, 5, 0, 1);
    add(16'h0020, 0, 0, 1, 5, 0, 1);
    add(16'h0020, 0, 0, 1, 5, 0, 1);
    add(16'h0020, 1, 0, 0, 5, 0, 1);
    add(16'h0020, 0, 0, 0, 5, 0, 0);
    add(16'h0021, 0, 0, 1, 0, 0, 1);
    add(16'h0021, 1, 0, 0, 0, 0, 1);
    add(16'h0000, 0, 0, 0, 0, 0, 0);
    // hold limit reached: 8 grant cycles then a timeout pulse
    for (int i = 0; i < MAX_HOLD; i++) add(16'h0100, 0, 0, 1, 8, 0, 1);
    add(16'h0100, 0, 0, 0, 8, 1, 1);
    add(16'h0100, 0, 0, 0, 8, 0, 0);
    // done on the last allowed cycle: no pulse
    for (int i = 0; i < MAX_HOLD; i++) add(16'h0100, 0, 0, 1, 8, 0, 1);
    add(16'h0100, 1, 0, 0, 8, 0, 1);
    add(16'h0100, 0, 0, 0, 8, 0, 0);

    foreach (tbl[i]) begin
      cyc(tbl[i].req, tbl[i].done, tbl[i].rst);
      chk($sformatf("tbl%0d_en", i),   grant_en,  tbl[i].en);
      chk($sformatf("tbl%0d_idx", i),  grant_idx, tbl[i].idx);
      chk($sformatf("tbl%0d_to", i),   timeout,   tbl[i].to);
      chk($sformatf("tbl%0d_busy", i), busy,      tbl[i].busy);
    end

    // rotation with all requesting and immediate done
    cyc(16'hFFFF, 1, 1);
    for (int g = 0; g <= 16; g++) begin
      cnt = 0;
      while (!grant_en && cnt < 8) begin
        cyc(16'hFFFF, 1, 0);
        cnt++;
      end
      chk("rot_seen", grant_en, 1);
      chk("rot_idx", grant_idx, g % 16);
      cyc(16'hFFFF, 1, 0);
      chk("rot_gap", grant_en, 0);
    end

    // wrap from ptr 14 skipping bits 14,15
    cyc(16'h0000, 0, 1);
    cyc(16'h2000, 0, 0);
    chk("wrap_g13", grant_idx, 13);
    cyc(16'h2000, 1, 0);
    cyc(16'h0000, 0, 0);
    cyc(16'h0009, 0, 0);
    chk("wrap_en0", grant_en, 1);
    chk("wrap_idx0", grant_idx, 0);
    cyc(16'h0009, 1, 0);
    cyc(16'h0009, 0, 0);
    cyc(16'h0009, 0, 0);
    chk("wrap_en3", grant_en, 1);
    chk("wrap_idx3", grant_idx, 3);

    // withdraw releases without timeout
    cyc(16'h0001, 0, 0);
    chk("wd_en", grant_en, 0);
    chk("wd_to", timeout, 0);
    chk("wd_busy", busy, 1);
    cyc(16'h0000, 0, 0);

    // reset mid-grant clears the enable and the pointer
    cyc(16'h0080, 0, 0);
    chk("rmg_en1", grant_en, 1);
    chk("rmg_idx7", grant_idx, 7);
    cyc(16'h0080, 0, 1);
    chk("rmg_en0", grant_en, 0);
    chk("rmg_idx0", grant_idx, 0);
    chk("rmg_busy", busy, 0);
    cyc(16'h0081, 0, 0);
    chk("rmg_ptr0", grant_idx, 0);
    chk("rmg_en", grant_en, 1);

    // random traffic checked by the model
    rr = 16'hFFFF;
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0: rr = 16'($urandom);
        1: rr = 16'h0001 << $urandom_range(0, 15);
        2: rr = 16'hFFFF;
        default: ;
      endcase
      cyc(rr, ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0));
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
